// File: rtl/juggle_pkg.sv
// juggle_pkg: shared types for the siteswap decoder (throw record, lane and FSM states)
package juggle_pkg;
    localparam int MAX_BALLS = 7;
    typedef struct packed {
        logic [2:0] value;
        logic [2:0] ball;
    } throw_t;
    typedef enum logic {HELD, AIR} lane_e;
    typedef enum logic [1:0] {IDLE, ARM, RUN} dec_state_e;
    function automatic logic [2:0] clamp_value(input logic [15:0] d);
        return (d > 16'd7) ? 3'd7 : d[2:0];
    endfunction
endpackage

// File: rtl/siteswap_decoder_if.sv
// siteswap_decoder_if: decoded-throw output handshake (valid/ready plus throw fields)
interface siteswap_decoder_if;
    logic       throw_valid_out;
    logic       throw_ready_in;
    logic [2:0] throw_value_out;
    logic [2:0] throw_ball_out;
    modport master(output throw_valid_out, throw_value_out, throw_ball_out, input throw_ready_in);
    modport slave(input throw_valid_out, throw_value_out, throw_ball_out, output throw_ready_in);
endinterface

// File: rtl/throw_fifo.sv
// throw_fifo: synchronous valid/ready queue of throw records; drops writes into a full, non-popping queue
module throw_fifo import juggle_pkg::*; #(
    parameter int DEPTH = 8
) (
    input  logic   clk_in,
    input  logic   rst_in,
    input  logic   wr_en,
    input  throw_t wr_data,
    output logic   rd_valid,
    input  logic   rd_ready,
    output throw_t rd_data,
    output logic   overflow
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    throw_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic pop, push, full;
    assign pop = rd_valid && rd_ready;
    assign full = count == (AW+1)'(DEPTH);
    assign push = wr_en && (!full || pop);
    assign overflow = wr_en && full && !pop;
    assign rd_valid = count != '0;
    assign rd_data = rd_valid ? mem[rd_ptr] : '0;
    always_ff @(posedge clk_in or negedge rst_in)
        if (!rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    always_ff @(posedge clk_in)
        if (push) mem[wr_ptr] <= wr_data;
endmodule

// File: rtl/siteswap_decoder.sv
// siteswap_decoder: turns per-ball y trajectories into siteswap throw values.
// SITESWAP_DECODER_FIFO_EN selects a FIFO_DEPTH queue; otherwise a single output register.
module siteswap_decoder import juggle_pkg::*; #(
    parameter int N_BALLS    = 7,
    parameter int HYST       = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [N_BALLS-1:0][10:0] traj_x_in,
    input  logic [N_BALLS-1:0][9:0]  traj_y_in,
    input  logic                     traj_valid_in,
    input  logic [2:0]               num_balls,
    input  logic [9:0]               hand_y_in,
    input  logic [15:0]              samples_per_beat,
    siteswap_decoder_if.master       tif,
    output logic                     overflow_out,
    output logic                     range_err_out,
    output logic                     overrun_out
);
    dec_state_e state, state_nx;
    lane_e lane_st [N_BALLS];
    logic [15:0] last_beat [N_BALLS];
    logic [15:0] diff [N_BALLS];
    logic [2:0] pend_val [N_BALLS];
    logic [N_BALLS-1:0] active, rise, fall, evt, emit, bad, logged, pend;
    logic [15:0] sample_cnt, beat_idx;
    logic [2:0] sel;
    logic run_mode, accept, wr_en, ovf, unused_x;
    throw_t wr_rec, out_rec;
    assign unused_x = ^traj_x_in;
    always_ff @(posedge clk_in or negedge rst_in)
        if (!rst_in) state <= IDLE;
        else state <= state_nx;
    always_comb
        state_nx = (state == IDLE) ? (traj_valid_in ? ARM : IDLE) :
                   (state == ARM) ? (((logged & active) == active) ? RUN : ARM) : RUN;
    always_comb run_mode = state == RUN;
    always_comb begin
        sel = '0;
        for (int l = N_BALLS - 1; l >= 0; l--) if (pend[l]) sel = 3'(l);
        for (int l = 0; l < N_BALLS; l++) begin
            active[l] = 3'(l) < num_balls;
            rise[l] = traj_valid_in && active[l] && lane_st[l] == HELD &&
                      (11'(traj_y_in[l]) + 11'(HYST) < 11'(hand_y_in));
            fall[l] = traj_valid_in && active[l] && lane_st[l] == AIR && traj_y_in[l] >= hand_y_in;
            diff[l] = beat_idx - last_beat[l];
            bad[l] = diff[l] == 16'd0 || diff[l] > 16'd7;
        end
        // a strobe arriving while throws are still being serialized loses its events
        accept = traj_valid_in && pend == '0;
        evt = accept ? rise : '0;
        emit = evt & (logged | {N_BALLS{run_mode}});
    end
    always_ff @(posedge clk_in or negedge rst_in)
        if (!rst_in) begin
            for (int l = 0; l < N_BALLS; l++) begin
                lane_st[l] <= HELD;
                last_beat[l] <= '0;
                pend_val[l] <= '0;
            end
            logged <= '0;
            pend <= '0;
            sample_cnt <= '0;
            beat_idx <= '0;
            wr_en <= 1'b0;
            wr_rec <= '0;
            overflow_out <= 1'b0;
            range_err_out <= 1'b0;
            overrun_out <= 1'b0;
        end else begin
            for (int l = 0; l < N_BALLS; l++) begin
                if (rise[l]) lane_st[l] <= AIR;
                else if (fall[l]) lane_st[l] <= HELD;
                if (evt[l]) begin
                    last_beat[l] <= beat_idx;
                    logged[l] <= 1'b1;
                    pend_val[l] <= clamp_value(diff[l]);
                end
            end
            if (traj_valid_in) begin
                sample_cnt <= (sample_cnt + 16'd1 == samples_per_beat) ? '0 : sample_cnt + 16'd1;
                if (sample_cnt + 16'd1 == samples_per_beat) beat_idx <= beat_idx + 16'd1;
            end
            pend <= (pend & ~(N_BALLS'(1) << sel)) | emit;
            wr_en <= |pend;
            wr_rec <= '{value: pend_val[sel], ball: sel};
            overflow_out <= overflow_out | ovf;
            range_err_out <= range_err_out | |(emit & bad);
            overrun_out <= overrun_out | (traj_valid_in && pend != '0);
        end
`ifdef SITESWAP_DECODER_FIFO_EN
    throw_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .wr_en(wr_en),
        .wr_data(wr_rec),
        .rd_valid(tif.throw_valid_out),
        .rd_ready(tif.throw_ready_in),
        .rd_data(out_rec),
        .overflow(ovf)
    );
`else
    localparam int unused_depth = FIFO_DEPTH;
    logic occ, pop;
    throw_t hold;
    assign pop = occ && tif.throw_ready_in;
    assign ovf = wr_en && occ && !pop;
    assign out_rec = occ ? hold : '0;
    assign tif.throw_valid_out = occ;
    always_ff @(posedge clk_in or negedge rst_in)
        if (!rst_in) begin
            occ <= 1'b0;
            hold <= '0;
        end else if (wr_en && (!occ || pop)) begin
            occ <= 1'b1;
            hold <= wr_rec;
        end else if (pop) occ <= 1'b0;
`endif
    assign tif.throw_value_out = out_rec.value;
    assign tif.throw_ball_out = out_rec.ball;
endmodule

// File: doc/siteswap_decoder.md
SITESWAP_DECODER -- requirements
Module: siteswap_decoder

Interface
REQ-001 SHALL have parameter N_BALLS, default 7, which is the number of ball position lanes.
REQ-002 SHALL have parameter HYST, default 4, which is the catch-line hysteresis in pixels.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, which is the depth of the decoded-throw queue.
REQ-004 clk_in  input  1  the only clock.
REQ-005 rst_in  input  1  asynchronous, active-low reset.
REQ-006 traj_x_in[N_BALLS-1:0]  input  11 each  ball x positions in pixels.
REQ-007 traj_y_in[N_BALLS-1:0]  input  10 each  ball y positions in pixels; y grows downward.
REQ-008 traj_valid_in  input  1  one-cycle sample strobe marking that all lanes are valid.
REQ-009 num_balls  input  3  number of active lanes, 1..7.
REQ-010 hand_y_in  input  10  catch-line y in pixels.
REQ-011 samples_per_beat  input  16  number of strobes per beat, nonzero.
REQ-012 throw_valid_out / throw_ready_in  output / input  1 each  output handshake.
REQ-013 throw_value_out  output  3  decoded siteswap value.
REQ-014 throw_ball_out  output  3  index of the thrown ball.
REQ-015 overflow_out, range_err_out, overrun_out  output  1 each  sticky error flags.

Function
REQ-016 SHALL run the FSM IDLE -> ARM -> RUN: IDLE leaves on the first traj_valid_in; ARM leaves once every active lane has logged one throw; RUN stays in RUN until reset.
REQ-017 SHALL keep per-lane state HELD/AIR, entered as HELD.
- HELD -> AIR, a throw event, when y < hand_y_in - HYST.
- AIR -> HELD when y >= hand_y_in.
- Lanes with index >= num_balls are ignored.
REQ-018 SHALL evaluate lanes only on traj_valid_in cycles.
REQ-019 SHALL keep sample_cnt (16b) and beat_idx (16b):
- sample_cnt increments per strobe and wraps to 0 at samples_per_beat.
- beat_idx increments on that wrap and wraps modulo 2^16.
REQ-020 On a throw event, SHALL compute value = beat_idx - last_beat[lane] (modulo 2^16), then store beat_idx into last_beat[lane].
REQ-021 In ARM, the first throw per lane SHALL only record last_beat and SHALL emit nothing.
REQ-022 SHALL output value 7 and set range_err_out when value > 7.
REQ-023 SHALL output value 0 and set range_err_out when value == 0.
REQ-024 SHALL latch throw events into a pending mask and serialize them lowest lane first, one queue write per cycle.
REQ-025 When a strobe arrives while the pending mask is nonzero, SHALL discard the new sample's events and set overrun_out.
REQ-026 SHALL hold the throw_value_out and throw_ball_out fields stable while throw_valid_out=1 and throw_ready_in=0; an entry pops on valid && ready.
REQ-027 On a write into a full queue, SHALL drop the new entry, keep the queue contents intact and set overflow_out.
REQ-028 On a simultaneous pop and write when full, SHALL accept the write and SHALL NOT set overflow_out.
REQ-029 Latency: SHALL assert throw_valid_out no earlier than 2 cycles after the strobe for the lowest pending lane; each further simultaneous lane follows +1 cycle.

Reset
REQ-030 On rst_in=0, SHALL asynchronously enter IDLE and set all lanes to HELD.
REQ-031 Reset SHALL clear last_beat, sample_cnt, beat_idx, the pending mask and the queue.
REQ-032 Reset SHALL drive all outputs to 0, including the sticky flags.
REQ-033 Sticky flags SHALL clear only on reset.
REQ-034 Reset in mid-RUN SHALL discard queued throws; after release the decoder SHALL re-arm from IDLE.

Configuration
REQ-035 With SITESWAP_DECODER_FIFO_EN defined, SHALL use a FIFO_DEPTH-entry queue.
REQ-036 Without SITESWAP_DECODER_FIFO_EN, SHALL replace the queue with a single output register; a write while it is occupied and not popping SHALL drop the entry and set overflow_out.

Structure
REQ-037 Package juggle_pkg SHALL hold MAX_BALLS=7, the throw record typedef (value 3b, ball 3b), the lane-state enum and the decoder FSM enum.
REQ-038 SHALL instantiate one sub-module, throw_fifo (synchronous FIFO with valid/ready), under the macro.

Verification
REQ-039 3-ball cascade: samples_per_beat=4, each ball thrown every 3 beats in rotation -> after ARM, a stream of value 3 with balls 0,1,2,0,...
REQ-040 Pattern 531: lane throw intervals 5,3,1 beats -> emitted values repeat 5,3,1; no flags set.
REQ-041 Lanes 0 and 2 thrown on the same strobe -> entries (ball 0) then (ball 2) on consecutive cycles.
REQ-042 throw_ready_in=0 and 9 throws with FIFO enabled -> 8 entries retained, overflow_out=1, first pop returns the oldest entry.
REQ-043 Lane 1 re-thrown after 9 beats -> value 7 and range_err_out=1.
REQ-044 rst_in pulsed low mid-RUN with 3 queued entries -> throw_valid_out=0 immediately, all flags 0, FSM back in IDLE.
